imem_port_arbiter: RTL

- Shares the single-port instruction ROM (1-cycle synchronous read, `InstMemNumLog2`-bit word address, `RegBus` data) between two requesters:
  - the IF stage (instruction fetch);
  - a load port (constant-table / lw-from-ROM reads issued by MEM).
- Fixed priority to fetch, with a starvation guard for the load port.
- Tags each in-flight read and routes the returning word to its owner.
- Supports fetch-response kill on a pipeline flush.
- Sits between the IF/MEM stages and the ROM wrapper.

---
 rtl/imem_port_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction ROM between instruction fetch and a load port.
// Fetch has fixed priority. A starvation counter forces a load grant once the load has waited long enough.
//
// owner   | meaning
// --------+-----------------------------------------------
// NONE    | no ROM read issued last cycle
// IF      | last cycle's read belongs to fetch
// LD      | last cycle's read belongs to the load port
module imem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              flush_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LD   = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  logic [3:0]        starve_cnt;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] ld_hold;
  logic              ld_force;

  assign ld_force = ld_req_i && (starve_cnt == STARVE_MAX);
  assign if_gnt_o = if_req_i && !ld_force;
  assign ld_gnt_o = ld_req_i && (ld_force || !if_req_i);
  assign rom_ce_o = if_gnt_o || ld_gnt_o;

  // An idle cycle keeps the previous address on the bus.
  always_comb begin
    rom_addr_o = last_addr;
    if (ld_gnt_o)      rom_addr_o = ld_addr_i;
    else if (if_gnt_o) rom_addr_o = if_addr_i;
  end

  assign if_rvalid_o = (owner == OWN_IF) && !flush_i;
  assign ld_rvalid_o = (owner == OWN_LD);
  assign if_data_o   = if_rvalid_o ? rom_data_i : if_hold;
  assign ld_data_o   = ld_rvalid_o ? rom_data_i : ld_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      owner      <= OWN_NONE;
      last_addr  <= '0;
      if_hold    <= '0;
      ld_hold    <= '0;
    end else begin
      if (!ld_req_i || ld_gnt_o)
        starve_cnt <= 4'd0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      if (ld_gnt_o)      owner <= OWN_LD;
      else if (if_gnt_o) owner <= OWN_IF;
      else               owner <= OWN_NONE;

      if (rom_ce_o)    last_addr <= rom_addr_o;
      // A killed fetch response leaves the fetch hold register untouched.
      if (if_rvalid_o) if_hold   <= rom_data_i;
      if (ld_rvalid_o) ld_hold   <= rom_data_i;
    end
  end

endmodule
